cmm_errman_msg_req: RTL

CMM_ERRMAN_MSG_REQ -- requirements
Module: cmm_errman_msg_req

---
 rtl/cmm_errman_pkg.sv | 29 ++
 rtl/cmm_errman_sat_cnt16.sv | 32 +++
 rtl/cmm_errman_msg_req.sv | 129 ++++++++++++
 3 files changed

// File: rtl/cmm_errman_pkg.sv
// Shared types and message codes for the error-manager message requester.
package cmm_errman_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    localparam logic [7:0] MSG_NONE = 8'h00;
    localparam logic [7:0] MSG_COR  = 8'h30;
    localparam logic [7:0] MSG_NFL  = 8'h31;
    localparam logic [7:0] MSG_FTL  = 8'h33;

    // Fixed priority FTL > NFL > COR over the eligible classes.
    function automatic logic [7:0] sel_code(input logic ftl, input logic nfl, input logic cor);
        logic [7:0] code;
        code = MSG_NONE;
        if (ftl) begin
            code = MSG_FTL;
        end else if (nfl) begin
            code = MSG_NFL;
        end else if (cor) begin
            code = MSG_COR;
        end
        return code;
    endfunction

endpackage

// File: rtl/cmm_errman_sat_cnt16.sv
// 16-bit saturating event counter with synchronous clear (clear wins over increment).
module cmm_errman_sat_cnt16 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inc,
    input  logic        clr,
    output logic [15:0] count
);

    logic [15:0] count_q;
    logic [15:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != 16'hFFFF)) begin
            count_d = count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/cmm_errman_msg_req.sv
// Error-message request FSM towards the TX arbiter with post-ack holdoff.
// Optional correctable-error messaging: define CMM_ERRMAN_COR_MSG_EN.
//
//  state   | meaning
//  IDLE    | evaluate pend & en, launch a request for the highest class
//  REQ     | msg_req/msg_code held stable until msg_ack
//  HOLD    | HOLD_CYC cycles for the error counter to absorb the decrement
module cmm_errman_msg_req
    import cmm_errman_pkg::*;
#(
    parameter int FFD      = 1,
    parameter int HOLD_CYC = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ftl_pend,
    input  logic        nfl_pend,
    input  logic        cor_pend,
    input  logic        ftl_en,
    input  logic        nfl_en,
    input  logic        cor_en,
    input  logic        msg_ack,
    input  logic        cnt_clr,
    output logic        msg_req,
    output logic [7:0]  msg_code,
    output logic        ftl_dec,
    output logic        nfl_dec,
    output logic        cor_dec,
    output logic [15:0] msg_cnt
);

    // Flops are modelled with zero delay; FFD is kept so instantiations stay compatible.
    localparam int         UNUSED_FFD = FFD;
    localparam logic [2:0] HOLD_LOAD  = 3'(HOLD_CYC - 1);

    state_e      state_q;
    logic        msg_req_q;
    logic [7:0]  msg_code_q;
    logic        ftl_dec_q;
    logic        nfl_dec_q;
    logic [2:0]  hold_cnt_q;
    logic        elig_ftl;
    logic        elig_nfl;
    logic        elig_cor;
    logic        ack_ok;

    assign elig_ftl = ftl_pend & ftl_en;
    assign elig_nfl = nfl_pend & nfl_en;

`ifdef CMM_ERRMAN_COR_MSG_EN
    logic cor_dec_q;
    assign elig_cor = cor_pend & cor_en;
    assign cor_dec  = cor_dec_q;
`else
    logic unused_cor;
    assign unused_cor = cor_pend ^ cor_en;
    assign elig_cor   = 1'b0;
    assign cor_dec    = 1'b0;
`endif

    assign ack_ok = (state_q == ST_REQ) && msg_ack;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            msg_req_q  <= 1'b0;
            msg_code_q <= MSG_NONE;
            ftl_dec_q  <= 1'b0;
            nfl_dec_q  <= 1'b0;
`ifdef CMM_ERRMAN_COR_MSG_EN
            cor_dec_q  <= 1'b0;
`endif
            hold_cnt_q <= '0;
        end else begin
            ftl_dec_q <= 1'b0;
            nfl_dec_q <= 1'b0;
`ifdef CMM_ERRMAN_COR_MSG_EN
            cor_dec_q <= 1'b0;
`endif
            case (state_q)
                ST_IDLE: begin
                    if (elig_ftl || elig_nfl || elig_cor) begin
                        state_q    <= ST_REQ;
                        msg_req_q  <= 1'b1;
                        msg_code_q <= sel_code(elig_ftl, elig_nfl, elig_cor);
                    end
                end
                ST_REQ: begin
                    // The latched code, not the live inputs, selects the decrement.
                    if (msg_ack) begin
                        state_q    <= ST_HOLD;
                        msg_req_q  <= 1'b0;
                        hold_cnt_q <= HOLD_LOAD;
                        ftl_dec_q  <= (msg_code_q == MSG_FTL);
                        nfl_dec_q  <= (msg_code_q == MSG_NFL);
`ifdef CMM_ERRMAN_COR_MSG_EN
                        cor_dec_q  <= (msg_code_q == MSG_COR);
`endif
                    end
                end
                ST_HOLD: begin
                    if (hold_cnt_q == 3'd0) begin
                        state_q <= ST_IDLE;
                    end else begin
                        hold_cnt_q <= hold_cnt_q - 3'd1;
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    msg_req_q <= 1'b0;
                end
            endcase
        end
    end

    cmm_errman_sat_cnt16 u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (ack_ok),
        .clr   (cnt_clr),
        .count (msg_cnt)
    );

    assign msg_req  = msg_req_q;
    assign msg_code = msg_code_q;
    assign ftl_dec  = ftl_dec_q;
    assign nfl_dec  = nfl_dec_q;

endmodule
